// File: rtl/johnson_phase_sequencer.sv
// rtl/johnson_phase_sequencer.sv - Johnson-counter phase sequencer with run/pause/drain control
module johnson_phase_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic [CNT_W-1:0]     num_cycles,
    output logic [WIDTH-1:0]     jstate,
    output logic [2*WIDTH-1:0]   phase,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     cycles_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] LAST     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   CNT_ONE  = {{CNT_W{1'b0}}, 1'b1};

    state_t             state, state_n;
    logic [WIDTH-1:0]   jstate_n;
    logic [WIDTH-1:0]   jstep;
    logic               wrap;
    logic [CNT_W-1:0]   count_q, count_n;
    logic [CNT_W-1:0]   cyc_n, cyc_sat;
    logic [CNT_W:0]     cyc_plus;
    logic               count_hit;
    logic               done_n;

    // Johnson code for sequence index k: k ones filling from the MSB, then draining from the MSB
    function automatic logic [WIDTH-1:0] jcode(input int k);
        if (k <= WIDTH)
            return ~(ALL_ONES >> k);
        else
            return ALL_ONES >> (k - WIDTH);
    endfunction

    assign jstep     = {~jstate[0], jstate[WIDTH-1:1]};
    assign wrap      = (jstate == LAST);
    assign cyc_plus  = {1'b0, cycles_done} + CNT_ONE;
    assign cyc_sat   = (cycles_done == CNT_MAX) ? cycles_done : cyc_plus[CNT_W-1:0];
    assign count_hit = (count_q != '0) && (cyc_plus >= {1'b0, count_q});
    assign busy      = (state != IDLE);

    always_comb begin
        state_n  = state;
        jstate_n = jstate;
        cyc_n    = cycles_done;
        count_n  = count_q;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                    count_n = num_cycles;
                    cyc_n   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = DRAIN;
                end else if (pause) begin
                    state_n = PAUSED;
                end else begin
                    jstate_n = jstep;
                    if (wrap) begin
                        cyc_n = cyc_sat;
                        if (count_hit) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
            end
            PAUSED: begin
                if (stop)
                    state_n = DRAIN;
                else if (!pause)
                    state_n = RUN;
            end
            DRAIN: begin
                if (jstate == '0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    jstate_n = jstep;
                    if (wrap) begin
                        cyc_n   = cyc_sat;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            jstate      <= '0;
            cycles_done <= '0;
            count_q     <= '0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            jstate      <= jstate_n;
            cycles_done <= cyc_n;
            count_q     <= count_n;
            done        <= done_n;
        end
    end

    always_comb begin
        phase = '0;
        for (int k = 0; k < 2*WIDTH; k++)
            phase[k] = busy && (jstate == jcode(k));
    end

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// tb/tb_johnson_phase_sequencer.sv - directed self-checking bench for johnson_phase_sequencer
module tb_johnson_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause;
    logic [7:0] num_cycles;
    logic [3:0] jstate;
    logic [7:0] phase;
    logic       busy, done;
    logic [7:0] cycles_done;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] seq [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1111, 4'b0111, 4'b0011, 4'b0001};

    johnson_phase_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .num_cycles(num_cycles), .jstate(jstate), .phase(phase),
        .busy(busy), .done(done), .cycles_done(cycles_done)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; num_cycles = 8'd0;
        tick();
        tick();
        check_vec("rst_jstate", jstate, 0);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_done", done, 0);
        check_vec("rst_phase", phase, 0);
        check_vec("rst_cycles", cycles_done, 0);
        rst = 1'b0;

        // counted run of 2 cycles; num_cycles change after start must be ignored
        num_cycles = 8'd2; start = 1'b1;
        tick();
        start = 1'b0; num_cycles = 8'd5;
        check_vec("run_busy_t1", busy, 1);
        check_vec("run_phase_t1", phase, 8'h01);
        check_vec("run_jstate_t1", jstate, 0);
        for (int i = 1; i < 16; i++) begin
            tick();
            check_vec($sformatf("run_j%0d", i), jstate, seq[i % 8]);
            check_vec($sformatf("run_ph%0d", i), phase, 8'h01 << (i % 8));
        end
        tick();
        check_vec("end_busy", busy, 0);
        check_vec("end_done", done, 1);
        check_vec("end_cycles", cycles_done, 2);
        check_vec("end_phase", phase, 0);
        check_vec("end_jstate", jstate, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_vec("idle_done_pulse", done, 0);
        check_vec("idle_stop_busy", busy, 0);
        check_vec("idle_cycles_hold", cycles_done, 2);

        // continuous run, stop+pause together at 1110 after two wraps -> DRAIN
        num_cycles = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check_vec("cont_j1110", jstate, 4'b1110);
        check_vec("cont_cycles2", cycles_done, 2);
        stop = 1'b1; pause = 1'b1;
        tick();
        stop = 1'b0;
        check_vec("drain_entry_j", jstate, 4'b1110);
        for (int i = 4; i < 8; i++) begin
            tick();
            check_vec($sformatf("drain_j%0d", i), jstate, seq[i]);
            check_vec($sformatf("drain_busy%0d", i), busy, 1);
        end
        tick();
        pause = 1'b0;
        check_vec("drain_end_j", jstate, 0);
        check_vec("drain_end_busy", busy, 0);
        check_vec("drain_end_done", done, 1);
        check_vec("drain_end_cycles", cycles_done, 3);

        // pause for 5 cycles at 1100, start while busy ignored
        num_cycles = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_vec("pause_pre_j", jstate, 4'b1100);
        pause = 1'b1; start = 1'b1; num_cycles = 8'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec($sformatf("pause_j%0d", i), jstate, 4'b1100);
            check_vec($sformatf("pause_ph%0d", i), phase, 8'h04);
            check_vec($sformatf("pause_busy%0d", i), busy, 1);
        end
        pause = 1'b0; start = 1'b0;
        tick();
        check_vec("resume_j", jstate, 4'b1100);
        for (int i = 3; i < 8; i++) begin
            tick();
            check_vec($sformatf("resume_j%0d", i), jstate, seq[i]);
            check_vec($sformatf("resume_done%0d", i), done, 0);
        end
        tick();
        check_vec("pause_end_busy", busy, 0);
        check_vec("pause_end_done", done, 1);
        check_vec("pause_end_cycles", cycles_done, 1);

        // stop while PAUSED at 0000 -> DRAIN, then IDLE with done
        num_cycles = 8'd0; start = 1'b1;
        tick();
        start = 1'b0; pause = 1'b1;
        tick();
        check_vec("p0_j", jstate, 0);
        check_vec("p0_phase", phase, 8'h01);
        stop = 1'b1;
        tick();
        stop = 1'b0; pause = 1'b0;
        check_vec("p0_drain_busy", busy, 1);
        check_vec("p0_drain_done", done, 0);
        tick();
        check_vec("p0_idle_busy", busy, 0);
        check_vec("p0_idle_done", done, 1);
        check_vec("p0_idle_cycles", cycles_done, 0);

        // reset mid-run at 0111 with one wrap completed
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        check_vec("mid_j0111", jstate, 4'b0111);
        check_vec("mid_cycles", cycles_done, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_vec("mrst_j", jstate, 0);
        check_vec("mrst_busy", busy, 0);
        check_vec("mrst_cycles", cycles_done, 0);
        check_vec("mrst_done", done, 0);
        tick();
        check_vec("mrst_done_after", done, 0);

        // continuous 260 cycles saturates the status counter
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 260 * 8; i++) tick();
        check_vec("sat_cycles", cycles_done, 255);
        check_vec("sat_busy", busy, 1);
        stop = 1'b1;
        begin
            int budget = 20;
            while (!done && budget > 0) begin
                tick();
                budget--;
            end
            check_vec("sat_drain_timeout", done, 1);
        end
        stop = 1'b0;
        check_vec("sat_final_cycles", cycles_done, 255);
        check_vec("sat_final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
